// File: rtl/pit_irq_ctrl.sv
// pit_irq_ctrl
//   Captures one-cycle interrupt pulses (source 0 is the interval timer) into
//   pending bits. Pending bits gated by MASK are presented one at a time, in
//   fixed priority order (lowest index first), over a valid/ack handshake.
//   Repeated pulses on an already-pending source bump a saturating per-source
//   overflow counter.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset, clears all state
//   irq_in     per-source event pulses, sampled every cycle
//   reg_we     register write strobe
//   reg_addr   0 MASK, 1 PENDING (W1C), 2 OVF_SEL, 3 OVF_CNT (write clears)
//   reg_wdata  write data
//   reg_rdata  combinational read data (pre-write value on a write cycle)
//   irq_valid  an interrupt is being presented
//   irq_id     index of the presented source
//   irq_ack    consumer accepts the presented interrupt
module pit_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int OVF_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  output logic               irq_valid,
  output logic [2:0]         irq_id,
  input  logic               irq_ack
);

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_SEL  = 2'd2;
  localparam logic [1:0] ADDR_OVF  = 2'd3;

  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic [NUM_SRC-1:0] pend_reg, pend_next;
  logic [2:0]         sel_reg, sel_next;
  logic [2:0]         id_reg, id_next;
  logic [OVF_W-1:0]   ovf_reg  [NUM_SRC];
  logic [OVF_W-1:0]   ovf_next [NUM_SRC];

  logic               wr_mask, wr_pend, wr_sel, wr_ovf;
  logic               ack_fire;
  logic [NUM_SRC-1:0] id_match, sel_match, clr_vec, req_vec;
  logic               cur_live;
  logic [2:0]         low_idx;
  logic [OVF_W-1:0]   ovf_rd;

  // Only some write-data bits are meaningful for small NUM_SRC.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  assign wr_mask = reg_we && (reg_addr == ADDR_MASK);
  assign wr_pend = reg_we && (reg_addr == ADDR_PEND);
  assign wr_sel  = reg_we && (reg_addr == ADDR_SEL);
  assign wr_ovf  = reg_we && (reg_addr == ADDR_OVF);

  // An ack only counts while something is actually being presented.
  assign ack_fire = (state_reg == ST_PRESENT) && irq_ack;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign id_match[gi]  = (id_reg == 3'(gi));
      assign sel_match[gi] = (sel_reg == 3'(gi));

      // Clear sources: W1C write or acceptance of this source's presentation.
      assign clr_vec[gi] = (wr_pend && reg_wdata[gi]) || (ack_fire && id_match[gi]);

      // A new event always wins over a simultaneous clear.
      assign pend_next[gi] = irq_in[gi] | (pend_reg[gi] & ~clr_vec[gi]);

      // An event on a pending bit that is not being cleared is a lost event.
      // The explicit counter clear takes precedence over a same-cycle bump.
      assign ovf_next[gi] =
          (wr_ovf && sel_match[gi]) ? '0 :
          (irq_in[gi] && pend_reg[gi] && !clr_vec[gi] && (ovf_reg[gi] != OVF_MAX))
            ? ovf_reg[gi] + 1'b1 : ovf_reg[gi];
    end
  endgenerate

  assign mask_next = wr_mask ? reg_wdata[NUM_SRC-1:0] : mask_reg;
  assign sel_next  = wr_sel  ? reg_wdata[2:0]         : sel_reg;

  assign req_vec  = pend_reg & mask_reg;
  // The presented source is still both pending and enabled.
  assign cur_live = |(id_match & req_vec);

  // Fixed priority: scan downward so the lowest requesting index wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req_vec) begin
          state_next = ST_PRESENT;
          id_next    = low_idx;
        end
      end
      ST_PRESENT: begin
        // Ack takes priority over withdrawal; withdrawal sees register
        // writes one cycle after they were issued.
        if (irq_ack) begin
          state_next = ST_IDLE;
        end else if (!cur_live) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      id_reg    <= '0;
      mask_reg  <= '0;
      pend_reg  <= '0;
      sel_reg   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        ovf_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      mask_reg  <= mask_next;
      pend_reg  <= pend_next;
      sel_reg   <= sel_next;
      for (int i = 0; i < NUM_SRC; i++) begin
        ovf_reg[i] <= ovf_next[i];
      end
    end
  end

  // OVF_SEL values beyond the implemented sources read back a zero count.
  always_comb begin
    ovf_rd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_match[i]) begin
        ovf_rd = ovf_reg[i];
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_MASK: reg_rdata = 8'(mask_reg);
      ADDR_PEND: reg_rdata = 8'(pend_reg);
      ADDR_SEL:  reg_rdata = 8'(sel_reg);
      ADDR_OVF:  reg_rdata = 8'(ovf_rd);
      default:   reg_rdata = '0;
    endcase
  end

  assign irq_valid = (state_reg == ST_PRESENT);
  assign irq_id    = id_reg;

endmodule

// File: tb/tb_pit_irq_ctrl.sv
module tb_pit_irq_ctrl;

  localparam int NUM_SRC = 4;
  localparam int OVF_W   = 4;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irq_in;
  logic               reg_we;
  logic [1:0]         reg_addr;
  logic [7:0]         reg_wdata;
  logic [7:0]         reg_rdata;
  logic               irq_valid;
  logic [2:0]         irq_id;
  logic               irq_ack;

  pit_irq_ctrl #(.NUM_SRC(NUM_SRC), .OVF_W(OVF_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_pend [NUM_SRC];
  bit m_mask [NUM_SRC];
  int m_ovf  [NUM_SRC];
  int m_sel;
  bit m_valid;
  int m_id;

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      m_pend[i] = 0;
      m_mask[i] = 0;
      m_ovf[i]  = 0;
    end
    m_sel   = 0;
    m_valid = 0;
    m_id    = 0;
  endtask

  function automatic int model_read(input int a);
    int v;
    v = 0;
    case (a)
      0: for (int i = 0; i < NUM_SRC; i++) v += m_mask[i] ? (1 << i) : 0;
      1: for (int i = 0; i < NUM_SRC; i++) v += m_pend[i] ? (1 << i) : 0;
      2: v = m_sel;
      default: v = (m_sel < NUM_SRC) ? m_ovf[m_sel] : 0;
    endcase
    return v;
  endfunction

  // One clock worth of behaviour, from the current inputs and current state.
  task automatic model_step();
    bit clr [NUM_SRC];
    bit np  [NUM_SRC];
    bit ack_fire;
    int lo;
    ack_fire = m_valid && irq_ack;
    if (ack_fire) $display("deliver id=%0d at t=%0t", m_id, $time);
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = (reg_we && reg_addr == 2'd1 && reg_wdata[i]) || (ack_fire && m_id == i);
      if (irq_in[i] && m_pend[i] && !clr[i] && m_ovf[i] < OVF_MAX) m_ovf[i]++;
      if (reg_we && reg_addr == 2'd3 && m_sel == i) m_ovf[i] = 0;
      np[i] = irq_in[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
    end
    if (m_valid) begin
      if (irq_ack) m_valid = 0;
      else if (!(m_pend[m_id] && m_mask[m_id])) m_valid = 0;
    end else begin
      lo = -1;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) lo = i;
      if (lo >= 0) begin
        m_valid = 1;
        m_id    = lo;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) m_pend[i] = np[i];
    if (reg_we && reg_addr == 2'd0) for (int i = 0; i < NUM_SRC; i++) m_mask[i] = reg_wdata[i];
    if (reg_we && reg_addr == 2'd2) m_sel = int'(reg_wdata[2:0]);
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic set_in(input logic [3:0] irq, input bit we, input logic [1:0] addr,
                        input logic [7:0] wd, input bit ack);
    irq_in    = irq;
    reg_we    = we;
    reg_addr  = addr;
    reg_wdata = wd;
    irq_ack   = ack;
    #1;
  endtask

  task automatic check_model();
    check("model_rdata", reg_rdata, model_read(reg_addr));
    check("model_valid", irq_valid, m_valid);
    if (m_valid) check("model_id", irq_id, m_id);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick(input logic [3:0] irq, input bit we, input logic [1:0] addr,
                      input logic [7:0] wd, input bit ack);
    set_in(irq, we, addr, wd, ack);
    check_model();
    advance();
  endtask

  typedef struct {
    logic [3:0] irq;
    bit         we;
    logic [1:0] addr;
    logic [7:0] wd;
    bit         ack;
    logic [7:0] rd;
    bit         valid;
    logic [2:0] id;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Basic timer delivery: enable source 0, pulse it, hold, then ack.
    tbl[0]  = '{4'h0, 1'b1, 2'd0, 8'h01, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{4'h1, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[2]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h01, 1'b0, 3'd0};
    tbl[3]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0};
    tbl[4]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0};
    tbl[5]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0};
    tbl[6]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0};
    tbl[7]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h01, 1'b1, 3'd0};
    tbl[8]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b1, 8'h01, 1'b1, 3'd0};
    tbl[9]  = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[10] = '{4'h0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0};

    rst = 1'b1;
    irq_in = '0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of every register.
    for (int a = 0; a < 4; a++) begin
      set_in(4'h0, 1'b0, 2'(a), 8'h00, 1'b0);
      check("reset_rdata", reg_rdata, 0);
    end
    check("reset_valid", irq_valid, 0);

    // Table-driven vectors.
    for (int r = 0; r < 11; r++) begin
      set_in(tbl[r].irq, tbl[r].we, tbl[r].addr, tbl[r].wd, tbl[r].ack);
      $display("vector %0d: rdata=%02h valid=%0d id=%0d", r, reg_rdata, irq_valid, irq_id);
      check("tbl_rdata", reg_rdata, tbl[r].rd);
      check("tbl_valid", irq_valid, tbl[r].valid);
      if (tbl[r].valid) check("tbl_id", irq_id, tbl[r].id);
      check_model();
      advance();
    end

    // Two simultaneous sources delivered in priority order with a gap.
    tick(4'h0, 1'b1, 2'd0, 8'h0F, 1'b0);
    tick(4'hA, 1'b0, 2'd1, 8'h00, 1'b0);
    tick(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b1);
    check("prio_first_valid", irq_valid, 1); check("prio_first_id", irq_id, 1);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b1);
    check("prio_gap_valid", irq_valid, 0);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b1);
    check("prio_second_valid", irq_valid, 1); check("prio_second_id", irq_id, 3);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    check("prio_pend_empty", reg_rdata, 0); check("prio_end_valid", irq_valid, 0);
    check_model(); advance();

    // Masked source overflow saturation and counter clear.
    tick(4'h0, 1'b1, 2'd0, 8'h00, 1'b0);
    for (int k = 0; k < 20; k++) tick(4'h4, 1'b0, 2'd1, 8'h00, 1'b0);
    tick(4'h0, 1'b1, 2'd2, 8'h02, 1'b0);
    set_in(4'h0, 1'b0, 2'd3, 8'h00, 1'b0);
    check("ovf_saturated", reg_rdata, 15); check("ovf_no_valid", irq_valid, 0);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    check("ovf_pend", reg_rdata, 4);
    check_model(); advance();
    tick(4'h0, 1'b1, 2'd3, 8'hFF, 1'b0);
    set_in(4'h0, 1'b0, 2'd3, 8'h00, 1'b0);
    check("ovf_cleared", reg_rdata, 0);
    check_model(); advance();
    tick(4'h0, 1'b1, 2'd1, 8'h04, 1'b0);

    // Withdrawal by W1C while presenting.
    tick(4'h0, 1'b1, 2'd0, 8'h01, 1'b0);
    tick(4'h1, 1'b0, 2'd1, 8'h00, 1'b0);
    tick(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    set_in(4'h0, 1'b1, 2'd1, 8'h01, 1'b0);
    check("wd_presented", irq_valid, 1);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    check("wd_w1_valid", irq_valid, 1); check("wd_w1_pend", reg_rdata, 0);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    check("wd_w2_valid", irq_valid, 0);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    check("wd_w3_valid", irq_valid, 0);
    check_model(); advance();

    // Ack coinciding with a new event on the same source.
    tick(4'h0, 1'b1, 2'd2, 8'h00, 1'b0);
    tick(4'h1, 1'b0, 2'd1, 8'h00, 1'b0);
    tick(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    set_in(4'h1, 1'b0, 2'd1, 8'h00, 1'b1);
    check("ackset_presented", irq_valid, 1);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd1, 8'h00, 1'b0);
    check("ackset_drop", irq_valid, 0); check("ackset_pend", reg_rdata, 1);
    check_model(); advance();
    set_in(4'h0, 1'b0, 2'd3, 8'h00, 1'b0);
    check("ackset_repres", irq_valid, 1); check("ackset_id", irq_id, 0);
    check("ackset_ovf", reg_rdata, 0);
    check_model();

    // Asynchronous reset in the middle of a presentation.
    #2 rst = 1'b1;
    #1;
    check("arst_valid", irq_valid, 0);
    check("arst_id", irq_id, 0);
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      check("arst_rdata", reg_rdata, 0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      logic [3:0] r_irq;
      bit         r_we;
      r_irq = 4'($urandom) & 4'($urandom) & 4'($urandom);
      r_we  = ($urandom_range(0, 3) == 0);
      tick(r_irq, r_we, 2'($urandom_range(0, 3)), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
